// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op codes follow the RV32M funct3 encoding.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } mdu_state_e;

    localparam int unsigned MDU_STEPS   = 32;
    localparam int unsigned MDU_LATENCY = 35;
    localparam int unsigned MDU_CNT_W   = 6;

    function automatic logic op_a_signed(mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_b_signed(mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Shared shift/accumulate datapath: radix-2 shift-add multiply and restoring divide
// on one 2*XLEN accumulator, plus the step counter. Operands arrive as magnitudes.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic                   step_i,
    input  logic                   is_div_i,
    input  logic [XLEN-1:0]        acc_init_i,
    input  logic [XLEN-1:0]        opnd_i,
    output logic [MDU_CNT_W-1:0]   cnt_o,
    output logic [2*XLEN-1:0]      acc_o
);

    localparam logic [MDU_CNT_W-1:0] CntOne = MDU_CNT_W'(1);

    logic [2*XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]      opnd_q, opnd_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN:0]        mul_sum;
    logic [XLEN+1:0]      div_diff;
    logic [2*XLEN-1:0]    mul_next, div_next;

    always_comb begin
        // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
        div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
        div_next = div_diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            acc_d  = {{XLEN{1'b0}}, acc_init_i};
            opnd_d = opnd_i;
            cnt_d  = '0;
        end else if (step_i) begin
            acc_d = is_div_i ? div_next : mul_next;
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with fixed latency and a one-cycle
// register-file write-back request. Sign handling and special cases live here.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam logic [MDU_CNT_W-1:0] StepsDone = MDU_CNT_W'(MDU_STEPS);
    localparam logic [XLEN-1:0]      MinInt    = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e state_q;
    mdu_op_e    op_q, op_in;
    logic [4:0] rd_q;
    logic       sign_a_q, sign_b_q, div_zero_q, ovf_q;
    logic       busy_q, done_q, wb_we_q;
    logic [4:0] rd_out_q;
    logic [XLEN-1:0] result_q;

    logic            sign_a, sign_b, accept, step;
    logic [XLEN-1:0] a_mag, b_mag, fix_result, quot, rem;
    logic [2*XLEN-1:0] acc, prod;
    logic [MDU_CNT_W-1:0] cnt;

    always_comb begin
        op_in  = mdu_op_e'(op);
        sign_a = op_a_signed(op_in) & rs1_val[XLEN-1];
        sign_b = op_b_signed(op_in) & rs2_val[XLEN-1];
        a_mag  = sign_a ? -rs1_val : rs1_val;
        b_mag  = sign_b ? -rs2_val : rs2_val;
        accept = (state_q == StIdle) && start && !flush;
        step   = (state_q == StCalc) && (cnt != StepsDone) && !flush;
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk_i      (clk),
        .rst_ni     (areset),
        .load_i     (accept),
        .step_i     (step),
        .is_div_i   (op_q[2]),
        .acc_init_i (op[2] ? a_mag : b_mag),
        .opnd_i     (op[2] ? b_mag : a_mag),
        .cnt_o      (cnt),
        .acc_o      (acc)
    );

    // A zero divisor leaves all-ones in the quotient and the dividend magnitude in the
    // remainder, so REM/REMU by zero already restore A once the sign is reapplied.
    always_comb begin
        prod       = (sign_a_q ^ sign_b_q) ? -acc : acc;
        quot       = (sign_a_q ^ sign_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem        = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_result = prod[XLEN-1:0];
        unique case (op_q)
            MDU_MUL:                         fix_result = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU: fix_result = div_zero_q ? '1 : (ovf_q ? MinInt : quot);
            MDU_REM, MDU_REMU: fix_result = ovf_q ? '0 : rem;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= StIdle;
            op_q       <= MDU_MUL;
            rd_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_we_q    <= 1'b0;
            rd_out_q   <= '0;
            result_q   <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wb_we_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: if (start) begin
                    state_q    <= StCalc;
                    busy_q     <= 1'b1;
                    op_q       <= op_in;
                    rd_q       <= rd_addr;
                    sign_a_q   <= sign_a;
                    sign_b_q   <= sign_b;
                    div_zero_q <= (rs2_val == '0);
                    ovf_q      <= (op_in inside {MDU_DIV, MDU_REM}) && (rs1_val == MinInt)
                                  && (rs2_val == '1);
                end
                StCalc: if (cnt == StepsDone) state_q <= StFix;
                StFix: begin
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    wb_we_q  <= (rd_q != 5'd0);
                    rd_out_q <= rd_q;
                    result_q <= fix_result;
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    wb_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wb_we  = wb_we_q;
    assign rd_out = rd_out_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random model checks and
// hand-written sequences for start-while-busy, flush and mid-operation reset.
module tb_mul_div_unit;

    localparam int LAT = 35;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        busy, done, wb_we;
    logic [4:0]  rd_out;
    logic [31:0] result;

    mul_div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .areset  (areset),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .rd_out  (rd_out),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb_s, ub, p;
        logic [63:0]        up;
        logic signed [31:0] a_s, b_s;
        sa   = {{32{a[31]}}, a};
        sb_s = {{32{b[31]}}, b};
        ub   = {32'd0, b};
        a_s  = a;
        b_s  = b;
        up   = {32'd0, a} * {32'd0, b};
        case (o)
            3'd0: return up[31:0];
            3'd1: begin p = sa * sb_s; return p[63:32]; end
            3'd2: begin p = sa * ub;   return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return a_s / b_s;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return a_s % b_s;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op and check its write-back; mid_start > 0 pulses a stray start then.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int mid_start);
        exp_t e;
        int   n;
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        e.res = exp_res; e.rd = rd;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("busy_in_calc", {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && n < LAT + 10) begin
            if (mid_start != 0 && n == mid_start) begin
                start = 1'b1; op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3; rd_addr = 5'd31;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(LAT));
        if (sb.size() > 0) e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("wb_we", {31'd0, wb_we}, {31'd0, (e.rd != 5'd0)});
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int d0;
        vecs = '{
            '{3'd0, 32'd7,         32'd6,         5'd5,  32'd42},
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'd0},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF},
            '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14},
            '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2},
            '{3'd4, 32'h1234,      32'd0,         5'd9,  32'hFFFF_FFFF},
            '{3'd6, 32'h1234,      32'd0,         5'd10, 32'h1234},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0},
            '{3'd0, 32'd5,         32'd5,         5'd0,  32'd25},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h4000_0000},
            '{3'd5, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF},
            '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1},
            '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD}
        };

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        check("rst_result", result, 32'd0);
        areset = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 0);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            run_op(o, a, b, 5'(i + 17), ref_model(o, a, b), 0);
        end

        // Stray start during CALC must be ignored: one done, original result.
        d0 = done_cnt;
        run_op(3'd0, 32'd9, 32'd9, 5'd20, 32'd81, 5);
        repeat (45) @(negedge clk);
        check("stray_start_dones", 32'(done_cnt - d0), 32'd1);

        // Flush mid-CALC: busy drops at the next edge, no done, prior result kept.
        @(negedge clk);
        op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd10; rd_addr = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        d0 = done_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (45) @(negedge clk);
        check("flush_no_done", 32'(done_cnt - d0), 32'd0);
        check("flush_result_kept", result, 32'd81);
        check("flush_rd_kept", {27'd0, rd_out}, 32'd20);

        // Asynchronous reset mid-CALC clears outputs at once; next op runs normally.
        @(negedge clk);
        op = 3'd0; rs1_val = 32'd5; rs2_val = 32'd5; rd_addr = 5'd22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        areset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_wb_we", {31'd0, wb_we}, 32'd0);
        check("arst_rd_out", {27'd0, rd_out}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        areset = 1'b1;
        run_op(3'd0, 32'd3, 32'd3, 5'd23, 32'd9, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
